tp_pattern_fill: RTL and testbench

Pixel-data stage that sits directly downstream of the VGA timing generator on `px_clk`. It consumes vsync/hsync/data-valid and fills the RGB888 bus with a selectable test pattern: colour bars, gray ramp, checkerboard, or a frame-counter solid. All sync outputs are delay-matched to the pixel data. It also flags active lines whose pixel count differs from `HACT`.

---
 rtl/tp_pattern_fill_pkg.sv | 29 ++
 rtl/tp_pattern_fill_if.sv | 26 ++
 rtl/tp_pattern_fill_pix_counter.sv | 103 ++++++++++
 rtl/tp_pattern_fill.sv | 117 +++++++++++
 tb/tb_tp_pattern_fill.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tp_pattern_fill_pkg.sv
// Shared types and sizes for the test-pattern fill stage and its timing generator.
package tp_pkg;

  localparam int unsigned HACT      = 640;
  localparam int unsigned VACT      = 480;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned BAR_IDX_W = 3;
  localparam int unsigned CH_W      = 8;

  typedef enum logic [1:0] {
    TP_BARS  = 2'd0,
    TP_RAMP  = 2'd1,
    TP_CHECK = 2'd2,
    TP_SOLID = 2'd3
  } tp_mode_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Expand a single colour bit to a full-scale channel value.
  function automatic logic [CH_W-1:0] bit_expand(input logic v);
    return v ? {CH_W{1'b1}} : {CH_W{1'b0}};
  endfunction

endpackage

// File: rtl/tp_pattern_fill_if.sv
// Sync/pixel bus between the VGA timing generator, the pattern stage and its sink.
interface tp_pattern_fill_if;

  logic       vsync_i;
  logic       hsync_i;
  logic       dval_i;
  logic [1:0] mode_i;
  logic       vsync_o;
  logic       hsync_o;
  logic       dval_o;
  logic [7:0] rdata_o;
  logic [7:0] gdata_o;
  logic [7:0] bdata_o;
  logic       line_err_o;

  modport master (
    output vsync_i, hsync_i, dval_i, mode_i,
    input  vsync_o, hsync_o, dval_o, rdata_o, gdata_o, bdata_o, line_err_o
  );

  modport slave (
    input  vsync_i, hsync_i, dval_i, mode_i,
    output vsync_o, hsync_o, dval_o, rdata_o, gdata_o, bdata_o, line_err_o
  );

endinterface

// File: rtl/tp_pattern_fill_pix_counter.sv
// Edge detection plus x / y / bar-index counters; outputs form pipeline stage 1.
module tp_pix_counter
  import tp_pkg::*;
#(
  parameter int unsigned HACT  = tp_pkg::HACT,
  parameter int unsigned VACT  = tp_pkg::VACT,
  parameter int unsigned BAR_W = 80
) (
  input  logic                 px_clk,
  input  logic                 sys_rst,
  input  logic                 i_vsync,
  input  logic                 i_hsync,
  input  logic                 i_dval,
  output logic                 o_vs_rise_c,
  output logic [X_W-1:0]       o_x,
  output logic [Y_W-1:0]       o_y,
  output logic [BAR_IDX_W-1:0] o_bar,
  output logic                 o_vsync,
  output logic                 o_hsync,
  output logic                 o_dval,
  output logic                 o_line_err
);

  localparam int unsigned            BP_W     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [X_W-1:0]         X_MAX    = '1;
  localparam logic [X_W-1:0]         X_HACT   = X_W'(HACT);
  localparam logic [Y_W-1:0]         Y_LAST   = Y_W'(VACT - 1);
  localparam logic [BP_W-1:0]        BP_LAST  = BP_W'(BAR_W - 1);
  localparam logic [BAR_IDX_W-1:0]   BAR_LAST = '1;

  logic [X_W-1:0]       r_x_cnt;
  logic [Y_W-1:0]       r_y_cnt;
  logic [BP_W-1:0]      r_bar_pix;
  logic [BAR_IDX_W-1:0] r_bar_idx;
  logic                 r_vsync_d;
  logic                 r_hsync_d;
  logic                 r_dval_d;
  logic [X_W-1:0]       r_x_q;
  logic [Y_W-1:0]       r_y_q;
  logic [BAR_IDX_W-1:0] r_bar_q;
  logic                 r_line_err;
  logic                 w_vs_rise;
  logic                 w_dval_fall;

  assign w_vs_rise   = i_vsync & ~r_vsync_d;
  assign w_dval_fall = ~i_dval & r_dval_d;

  // Counters hold the index of the pixel presented this cycle; stage-1 regs capture it.
  always_ff @(posedge px_clk) begin
    if (sys_rst) begin
      r_x_cnt    <= '0;
      r_y_cnt    <= '0;
      r_bar_pix  <= '0;
      r_bar_idx  <= '0;
      r_vsync_d  <= 1'b0;
      r_hsync_d  <= 1'b0;
      r_dval_d   <= 1'b0;
      r_x_q      <= '0;
      r_y_q      <= '0;
      r_bar_q    <= '0;
      r_line_err <= 1'b0;
    end else begin
      r_vsync_d  <= i_vsync;
      r_hsync_d  <= i_hsync;
      r_dval_d   <= i_dval;
      r_x_q      <= r_x_cnt;
      r_y_q      <= r_y_cnt;
      r_bar_q    <= r_bar_idx;
      r_line_err <= w_dval_fall & (r_x_cnt != X_HACT);

      if (i_dval) begin
        if (r_x_cnt != X_MAX) r_x_cnt <= r_x_cnt + X_W'(1);
        if (r_bar_pix == BP_LAST) begin
          r_bar_pix <= '0;
          if (r_bar_idx != BAR_LAST) r_bar_idx <= r_bar_idx + BAR_IDX_W'(1);
        end else begin
          r_bar_pix <= r_bar_pix + BP_W'(1);
        end
      end else begin
        r_x_cnt   <= '0;
        r_bar_pix <= '0;
        r_bar_idx <= '0;
      end

      // Frame start takes priority over an end-of-line in the same cycle.
      if (w_vs_rise) begin
        r_y_cnt <= '0;
      end else if (w_dval_fall && (r_y_cnt != Y_LAST)) begin
        r_y_cnt <= r_y_cnt + Y_W'(1);
      end
    end
  end

  assign o_vs_rise_c = w_vs_rise;
  assign o_x         = r_x_q;
  assign o_y         = r_y_q;
  assign o_bar       = r_bar_q;
  assign o_vsync     = r_vsync_d;
  assign o_hsync     = r_hsync_d;
  assign o_dval      = r_dval_d;
  assign o_line_err  = r_line_err;

endmodule

// File: rtl/tp_pattern_fill.sv
// Test-pattern fill stage: two-cycle pipeline from timing-generator syncs to RGB888.
module tp_pattern_fill
  import tp_pkg::*;
#(
  parameter int unsigned HACT      = tp_pkg::HACT,
  parameter int unsigned VACT      = tp_pkg::VACT,
  parameter int unsigned BAR_W     = 80,
  parameter int unsigned CHK_SHIFT = 5
) (
  input  logic               px_clk,
  input  logic               sys_rst,
  tp_pattern_fill_if.slave   bus
);

  logic                 w_vs_rise_c;
  logic [X_W-1:0]       w_x;
  logic [Y_W-1:0]       w_y;
  logic [BAR_IDX_W-1:0] w_bar;
  logic                 w_vsync_s1;
  logic                 w_hsync_s1;
  logic                 w_dval_s1;
  logic                 w_err_s1;
  logic                 w_chk;
  logic                 w_unused;
  rgb_t                 w_rgb;

  tp_mode_e             r_mode_q;
  logic [CH_W-1:0]      r_frame_cnt;
  logic                 r_vsync_o;
  logic                 r_hsync_o;
  logic                 r_dval_o;
  logic                 r_line_err;
  rgb_t                 r_rgb;

  tp_pix_counter #(
    .HACT  (HACT),
    .VACT  (VACT),
    .BAR_W (BAR_W)
  ) u_pix_counter (
    .px_clk      (px_clk),
    .sys_rst     (sys_rst),
    .i_vsync     (bus.vsync_i),
    .i_hsync     (bus.hsync_i),
    .i_dval      (bus.dval_i),
    .o_vs_rise_c (w_vs_rise_c),
    .o_x         (w_x),
    .o_y         (w_y),
    .o_bar       (w_bar),
    .o_vsync     (w_vsync_s1),
    .o_hsync     (w_hsync_s1),
    .o_dval      (w_dval_s1),
    .o_line_err  (w_err_s1)
  );

  assign w_chk    = w_x[CHK_SHIFT] ^ w_y[CHK_SHIFT];
  assign w_unused = ^{w_x[1:0], w_y[0]};

  // Pattern select on stage-1 coordinates; blanked outside active video.
  always_comb begin
    w_rgb = '0;
    case (r_mode_q)
      TP_BARS: begin
        w_rgb.r = bit_expand(~w_bar[1]);
        w_rgb.g = bit_expand(~w_bar[2]);
        w_rgb.b = bit_expand(~w_bar[0]);
      end
      TP_RAMP: begin
        w_rgb.r = w_x[X_W-1:2];
        w_rgb.g = w_x[X_W-1:2];
        w_rgb.b = w_x[X_W-1:2];
      end
      TP_CHECK: begin
        w_rgb.r = bit_expand(w_chk);
        w_rgb.g = bit_expand(w_chk);
        w_rgb.b = bit_expand(w_chk);
      end
      TP_SOLID: begin
        w_rgb.r = r_frame_cnt;
        w_rgb.g = ~r_frame_cnt;
        w_rgb.b = w_y[Y_W-1:1];
      end
    endcase
    if (!w_dval_s1) w_rgb = '0;
  end

  // Mode and frame count only change at frame start, so a frame is never mixed.
  always_ff @(posedge px_clk) begin
    if (sys_rst) begin
      r_mode_q    <= TP_BARS;
      r_frame_cnt <= '0;
      r_vsync_o   <= 1'b0;
      r_hsync_o   <= 1'b0;
      r_dval_o    <= 1'b0;
      r_line_err  <= 1'b0;
      r_rgb       <= '0;
    end else begin
      if (w_vs_rise_c) begin
        r_mode_q    <= tp_mode_e'(bus.mode_i);
        r_frame_cnt <= r_frame_cnt + CH_W'(1);
      end
      r_vsync_o  <= w_vsync_s1;
      r_hsync_o  <= w_hsync_s1;
      r_dval_o   <= w_dval_s1;
      r_line_err <= w_err_s1;
      r_rgb      <= w_rgb;
    end
  end

  assign bus.vsync_o    = r_vsync_o;
  assign bus.hsync_o    = r_hsync_o;
  assign bus.dval_o     = r_dval_o;
  assign bus.rdata_o    = r_rgb.r;
  assign bus.gdata_o    = r_rgb.g;
  assign bus.bdata_o    = r_rgb.b;
  assign bus.line_err_o = r_line_err;

endmodule

// File: tb/tb_tp_pattern_fill.sv
// Bench for tp_pattern_fill: frame-level stimulus against a pixel-rule reference model.
module tb_tp_pattern_fill;
  import tp_pkg::*;

  localparam int T_HACT  = 640;
  localparam int T_VACT  = 480;
  localparam int T_BAR_W = 80;
  localparam int T_CHK   = 5;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic px_clk  = 1'b0;
  logic sys_rst = 1'b1;
  always #5 px_clk = ~px_clk;

  tp_pattern_fill_if bus();

  tp_pattern_fill #(
    .HACT      (T_HACT),
    .VACT      (T_VACT),
    .BAR_W     (T_BAR_W),
    .CHK_SHIFT (T_CHK)
  ) dut (
    .px_clk  (px_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int compared = 0;
  int mism     = 0;

  bit d_vs, d_hs, d_dv, d_rst;
  int d_mode;

  int m_run, m_line, m_frame, m_mode;
  bit m_prev_dv, m_prev_vs;

  logic [27:0] exp_prev = '0;
  logic [23:0] obs_rgb [1024];
  int          obs_x    = 0;
  int          err_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_line = 0; m_frame = 0; m_mode = 0;
    m_prev_dv = 1'b0; m_prev_vs = 1'b0;
  endfunction

  // Expected output word {vs,hs,dv,r,g,b,err} for the pixel presented this cycle.
  function automatic logic [27:0] model_cycle(input bit vs, input bit hs, input bit dv,
                                              input int mode);
    bit rise, fall, err;
    int x, y, bi, v;
    logic [23:0] rgb;
    rise = vs && !m_prev_vs;
    fall = !dv && m_prev_dv;
    if (rise) begin
      m_frame = (m_frame + 1) % 256;
      m_mode  = mode;
    end
    x   = m_run;
    y   = m_line;
    rgb = '0;
    if (dv) begin
      case (m_mode)
        0: begin
          bi = x / T_BAR_W;
          if (bi > 7) bi = 7;
          rgb = BAR_RGB[bi];
        end
        1: begin
          v   = x / 4;
          rgb = {8'(v), 8'(v), 8'(v)};
        end
        2: begin
          v   = (((x >> T_CHK) ^ (y >> T_CHK)) & 1) != 0 ? 255 : 0;
          rgb = {8'(v), 8'(v), 8'(v)};
        end
        default: rgb = {8'(m_frame), 8'(255 - m_frame), 8'(y / 2)};
      endcase
    end
    err = fall && (m_run != T_HACT);
    if (dv) begin
      if (m_run < 1023) m_run++;
    end else begin
      m_run = 0;
    end
    if (rise) m_line = 0;
    else if (fall && m_line < T_VACT - 1) m_line++;
    m_prev_dv = dv;
    m_prev_vs = vs;
    return {vs, hs, dv, rgb, err};
  endfunction

  // One clock: drive, advance model, compare outputs with the pixel from the previous cycle.
  task automatic step();
    logic [27:0] e, got, want;
    bus.vsync_i = d_vs;
    bus.hsync_i = d_hs;
    bus.dval_i  = d_dv;
    bus.mode_i  = 2'(d_mode);
    sys_rst     = d_rst;
    if (d_rst) begin
      model_reset();
      e = '0;
    end else begin
      e = model_cycle(d_vs, d_hs, d_dv, d_mode);
    end
    @(posedge px_clk);
    #1;
    got  = {bus.vsync_o, bus.hsync_o, bus.dval_o, bus.rdata_o, bus.gdata_o, bus.bdata_o,
            bus.line_err_o};
    want = d_rst ? 28'd0 : exp_prev;
    chk("pipe_out", 32'(got), 32'(want));
    exp_prev = e;
    if (bus.dval_o) begin
      if (obs_x < 1024) obs_rgb[obs_x] = {bus.rdata_o, bus.gdata_o, bus.bdata_o};
      obs_x++;
    end else begin
      obs_x = 0;
    end
    if (bus.line_err_o) err_seen++;
  endtask

  task automatic frame_start();
    d_vs = 1'b0; d_hs = 1'b0; d_dv = 1'b0;
    repeat (3) step();
    d_vs = 1'b1;
    repeat (2) step();
  endtask

  task automatic run_line(input int len, input int gap);
    d_dv = 1'b1; d_hs = 1'b0;
    repeat (len) step();
    d_dv = 1'b0;
    for (int i = 0; i < gap; i++) begin
      d_hs = (i == 1) || (i == 2);
      step();
    end
    d_hs = 1'b0;
  endtask

  initial begin
    int e0, nl, sel, len, wraps;
    bit have_prev;
    logic [7:0] prev_r, prev_g;
    logic [23:0] cur;

    obs_rgb = '{default: '0};
    d_vs = 0; d_hs = 0; d_dv = 0; d_mode = 0; d_rst = 1;
    model_reset();

    // Reset held with toggling inputs: every output must read zero.
    for (int i = 0; i < 5; i++) begin
      d_vs = 1'($urandom_range(0, 1));
      d_hs = 1'($urandom_range(0, 1));
      d_dv = 1'($urandom_range(0, 1));
      d_mode = int'($urandom_range(0, 3));
      step();
    end
    d_rst = 0; d_vs = 0; d_hs = 0; d_dv = 0; d_mode = int'(TP_BARS);
    repeat (2) step();

    // Colour bars on a full line, then a short line, then a mid-frame mode change.
    frame_start();
    e0 = err_seen;
    run_line(640, 8);
    chk("bars_x0",   32'(obs_rgb[0]),   32'h00FFFFFF);
    chk("bars_x80",  32'(obs_rgb[80]),  32'h00FFFF00);
    chk("bars_x160", 32'(obs_rgb[160]), 32'h0000FFFF);
    chk("bars_x639", 32'(obs_rgb[639]), 32'h00000000);
    chk("err_640",   32'(err_seen - e0), 32'd0);
    e0 = err_seen;
    run_line(639, 8);
    chk("err_639",   32'(err_seen - e0), 32'd1);
    d_mode = int'(TP_RAMP);
    run_line(640, 8);
    chk("midswitch_bars", 32'(obs_rgb[0]), 32'h00FFFFFF);
    frame_start();
    run_line(640, 8);
    chk("ramp_x100", 32'(obs_rgb[100]), 32'h00191919);

    // Checkerboard across the first square boundary in x and y.
    d_mode = int'(TP_CHECK);
    frame_start();
    for (int l = 0; l < 33; l++) begin
      run_line(64, 4);
      if (l == 0) begin
        chk("chk_31_0", 32'(obs_rgb[31]), 32'h00000000);
        chk("chk_32_0", 32'(obs_rgb[32]), 32'h00FFFFFF);
      end
      if (l == 32) begin
        chk("chk_32_32", 32'(obs_rgb[32]), 32'h00000000);
        chk("chk_0_32",  32'(obs_rgb[0]),  32'h00FFFFFF);
      end
    end

    // Reset in the middle of an active line.
    d_mode = int'(TP_RAMP);
    frame_start();
    d_dv = 1'b1;
    repeat (50) step();
    d_rst = 1'b1;
    repeat (2) step();
    d_rst = 1'b0;
    e0 = err_seen;
    repeat (30) step();
    d_dv = 1'b0;
    repeat (6) step();
    chk("rst_mid_x10", 32'(obs_rgb[10]), 32'h00020202);
    chk("rst_mid_err", 32'(err_seen - e0), 32'd1);

    // Randomised frames: modes, line lengths (incl. x saturation), gaps, mid-frame mode noise.
    for (int f = 0; f < 10; f++) begin
      d_mode = int'($urandom_range(0, 3));
      frame_start();
      nl = int'($urandom_range(1, 4));
      for (int l = 0; l < nl; l++) begin
        sel = int'($urandom_range(0, 4));
        case (sel)
          0: len = 640;
          1: len = 639;
          2: len = 641;
          3: len = 1030;
          default: len = int'($urandom_range(1, 700));
        endcase
        run_line(len, int'($urandom_range(4, 12)));
        if ($urandom_range(0, 2) == 0) d_mode = int'($urandom_range(0, 3));
      end
    end

    // Frame counter wrap in solid mode.
    d_mode = int'(TP_SOLID);
    have_prev = 1'b0;
    prev_r = '0;
    prev_g = '0;
    wraps = 0;
    for (int f = 0; f < 257; f++) begin
      frame_start();
      run_line(4, 4);
      cur = obs_rgb[0];
      if (have_prev && prev_r == 8'd255) begin
        wraps++;
        chk("wrap_r_next", 32'(cur[23:16]), 32'd0);
        chk("wrap_g_next", 32'(cur[15:8]),  32'd255);
        chk("wrap_g_prev", 32'(prev_g),     32'd0);
      end
      prev_r = cur[23:16];
      prev_g = cur[15:8];
      have_prev = 1'b1;
    end
    chk("wrap_count", 32'(wraps), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
